// File: rtl/gpio_scan_sram_ctrl.sv
// Scan-chain SRAM test responder: a serial command packet is shifted in, a
// global_csb falling edge issues one access to the selected macro pair, and read data is folded back into the chain.
module gpio_scan_sram_ctrl #(
    parameter int SEL_W  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic              global_csb,
    input  logic              sram_load,
    output logic [SEL_W-1:0]  sel_o,
    output logic [ADDR_W-1:0] addr0_o,
    output logic [ADDR_W-1:0] addr1_o,
    output logic [DATA_W-1:0] din0_o,
    output logic [DATA_W-1:0] din1_o,
    output logic              csb0_o,
    output logic              csb1_o,
    output logic              web0_o,
    output logic              web1_o,
    output logic [MASK_W-1:0] wmask0_o,
    output logic [MASK_W-1:0] wmask1_o,
    input  logic [DATA_W-1:0] dout0_i,
    input  logic [DATA_W-1:0] dout1_i,
    output logic              busy_o
);

    localparam int CHAIN_W = SEL_W + 2 * (ADDR_W + DATA_W + 2 + MASK_W);

    // Field positions, LSB upward: port 1 fields sit below port 0 fields.
    localparam int WMASK1_LSB = 0;
    localparam int WEB1_BIT   = WMASK1_LSB + MASK_W;
    localparam int CSB1_BIT   = WEB1_BIT + 1;
    localparam int DIN1_LSB   = CSB1_BIT + 1;
    localparam int ADDR1_LSB  = DIN1_LSB + DATA_W;
    localparam int WMASK0_LSB = ADDR1_LSB + ADDR_W;
    localparam int WEB0_BIT   = WMASK0_LSB + MASK_W;
    localparam int CSB0_BIT   = WEB0_BIT + 1;
    localparam int DIN0_LSB   = CSB0_BIT + 1;
    localparam int ADDR0_LSB  = DIN0_LSB + DATA_W;
    localparam int SEL_LSB    = ADDR0_LSB + ADDR_W;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CHAIN_W-1:0]  chain;
    logic                csb_q;
    logic [2:0]          wait_cnt;
    logic                rd_flag0;
    logic                rd_flag1;
    logic                rd_vld0;
    logic                rd_vld1;
    logic [DATA_W-1:0]   cap0;
    logic [DATA_W-1:0]   cap1;

    logic idle_like;
    logic csb_fall;
    logic do_shift;
    logic do_issue;
    logic do_load;
    logic wait_last;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign csb_fall  = !global_csb && csb_q;
    assign do_shift  = idle_like && scan_en;
    assign do_issue  = idle_like && !scan_en && csb_fall;
    assign do_load   = idle_like && !scan_en && !csb_fall && sram_load;
    assign wait_last = (state == WAIT) && (wait_cnt == LAST_CNT);

    assign scan_out = chain[CHAIN_W-1];
    assign busy_o   = (state == ISSUE) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (do_issue) state_nxt = ISSUE;
            ISSUE:      state_nxt = WAIT;
            WAIT:       if (wait_last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain    <= '0;
            csb_q    <= 1'b1;
            wait_cnt <= '0;
            rd_flag0 <= 1'b0;
            rd_flag1 <= 1'b0;
            rd_vld0  <= 1'b0;
            rd_vld1  <= 1'b0;
            cap0     <= '0;
            cap1     <= '0;
            sel_o    <= '0;
            addr0_o  <= '0;
            addr1_o  <= '0;
            din0_o   <= '0;
            din1_o   <= '0;
            wmask0_o <= '0;
            wmask1_o <= '0;
            csb0_o   <= 1'b1;
            csb1_o   <= 1'b1;
            web0_o   <= 1'b1;
            web1_o   <= 1'b1;
        end else begin
            csb_q <= global_csb;

            if (do_shift) begin
                chain <= {chain[CHAIN_W-2:0], scan_in};
            end

            // Only ports that completed a read overwrite their din field.
            if (do_load) begin
                if (rd_vld0) chain[DIN0_LSB +: DATA_W] <= cap0;
                if (rd_vld1) chain[DIN1_LSB +: DATA_W] <= cap1;
            end

            if (do_issue) begin
                sel_o    <= chain[SEL_LSB +: SEL_W];
                addr0_o  <= chain[ADDR0_LSB +: ADDR_W];
                din0_o   <= chain[DIN0_LSB +: DATA_W];
                csb0_o   <= chain[CSB0_BIT];
                web0_o   <= chain[WEB0_BIT];
                wmask0_o <= chain[WMASK0_LSB +: MASK_W];
                addr1_o  <= chain[ADDR1_LSB +: ADDR_W];
                din1_o   <= chain[DIN1_LSB +: DATA_W];
                csb1_o   <= chain[CSB1_BIT];
                web1_o   <= chain[WEB1_BIT];
                wmask1_o <= chain[WMASK1_LSB +: MASK_W];
            end

            // Strobes are live for the ISSUE cycle only; the rest of the bus holds.
            if (state == ISSUE) begin
                csb0_o   <= 1'b1;
                csb1_o   <= 1'b1;
                web0_o   <= 1'b1;
                web1_o   <= 1'b1;
                rd_flag0 <= !csb0_o && web0_o;
                rd_flag1 <= !csb1_o && web1_o;
                rd_vld0  <= 1'b0;
                rd_vld1  <= 1'b0;
                wait_cnt <= '0;
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
                if (wait_last) begin
                    if (rd_flag0) begin
                        cap0    <= dout0_i;
                        rd_vld0 <= 1'b1;
                    end
                    if (rd_flag1) begin
                        cap1    <= dout1_i;
                        rd_vld1 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_scan_sram_ctrl.sv
// Bench for gpio_scan_sram_ctrl: two instances (read latency 1 and 3) share stimulus
// and are compared every cycle against a packet-level reference model.
module tb_gpio_scan_sram_ctrl;

    localparam int CW = 112;

    logic        clk = 1'b0;
    logic        resetn;
    logic        scan_en;
    logic        scan_in;
    logic        global_csb;
    logic        sram_load;
    logic [31:0] dout0_i;
    logic [31:0] dout1_i;

    logic        scan_out [2];
    logic [3:0]  sel_o    [2];
    logic [15:0] addr0_o  [2];
    logic [15:0] addr1_o  [2];
    logic [31:0] din0_o   [2];
    logic [31:0] din1_o   [2];
    logic        csb0_o   [2];
    logic        csb1_o   [2];
    logic        web0_o   [2];
    logic        web1_o   [2];
    logic [3:0]  wmask0_o [2];
    logic [3:0]  wmask1_o [2];
    logic        busy_o   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gpio_scan_sram_ctrl #(.RD_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .scan_en    (scan_en),
            .scan_in    (scan_in),
            .scan_out   (scan_out[g]),
            .global_csb (global_csb),
            .sram_load  (sram_load),
            .sel_o      (sel_o[g]),
            .addr0_o    (addr0_o[g]),
            .addr1_o    (addr1_o[g]),
            .din0_o     (din0_o[g]),
            .din1_o     (din1_o[g]),
            .csb0_o     (csb0_o[g]),
            .csb1_o     (csb1_o[g]),
            .web0_o     (web0_o[g]),
            .web1_o     (web1_o[g]),
            .wmask0_o   (wmask0_o[g]),
            .wmask1_o   (wmask1_o[g]),
            .dout0_i    (dout0_i),
            .dout1_i    (dout1_i),
            .busy_o     (busy_o[g])
        );
    end

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state, one copy per latency.
    logic [CW-1:0] m_chain [2];
    logic [CW-1:0] m_pkt   [2];
    logic          m_csb0  [2];
    logic          m_web0  [2];
    logic          m_csb1  [2];
    logic          m_web1  [2];
    logic          m_csbq  [2];
    logic          m_rd0   [2];
    logic          m_rd1   [2];
    logic          m_vld0  [2];
    logic          m_vld1  [2];
    logic [31:0]   m_cap0  [2];
    logic [31:0]   m_cap1  [2];
    int            m_busy  [2];

    int n_c0low [2];
    int n_c1low [2];
    int n_busy  [2];

    function automatic logic [CW-1:0] pack(logic [3:0] sel, logic [15:0] a0, logic [31:0] d0,
                                           logic c0, logic w0, logic [3:0] m0,
                                           logic [15:0] a1, logic [31:0] d1,
                                           logic c1, logic w1, logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    function automatic logic [CW-1:0] rand_pkt();
        return {$urandom, $urandom, $urandom, 16'($urandom)};
    endfunction

    task automatic model_edge(input int k);
        int lat;
        lat = (k == 0) ? 1 : 3;
        if (!resetn) begin
            m_chain[k] = '0;
            m_pkt[k]   = '0;
            m_csb0[k]  = 1'b1;
            m_web0[k]  = 1'b1;
            m_csb1[k]  = 1'b1;
            m_web1[k]  = 1'b1;
            m_csbq[k]  = 1'b1;
            m_rd0[k]   = 1'b0;
            m_rd1[k]   = 1'b0;
            m_vld0[k]  = 1'b0;
            m_vld1[k]  = 1'b0;
            m_cap0[k]  = '0;
            m_cap1[k]  = '0;
            m_busy[k]  = 0;
        end else begin
            if (m_busy[k] > 0) begin
                if (m_busy[k] == lat + 1) begin
                    m_csb0[k] = 1'b1;
                    m_web0[k] = 1'b1;
                    m_csb1[k] = 1'b1;
                    m_web1[k] = 1'b1;
                end
                if (m_busy[k] == 1) begin
                    if (m_rd0[k]) begin
                        m_cap0[k] = dout0_i;
                        m_vld0[k] = 1'b1;
                    end
                    if (m_rd1[k]) begin
                        m_cap1[k] = dout1_i;
                        m_vld1[k] = 1'b1;
                    end
                end
                m_busy[k] = m_busy[k] - 1;
            end else if (scan_en) begin
                m_chain[k] = {m_chain[k][CW-2:0], scan_in};
            end else if (!global_csb && m_csbq[k]) begin
                m_pkt[k]  = m_chain[k];
                m_csb0[k] = m_chain[k][59];
                m_web0[k] = m_chain[k][58];
                m_csb1[k] = m_chain[k][5];
                m_web1[k] = m_chain[k][4];
                m_rd0[k]  = !m_chain[k][59] && m_chain[k][58];
                m_rd1[k]  = !m_chain[k][5] && m_chain[k][4];
                m_vld0[k] = 1'b0;
                m_vld1[k] = 1'b0;
                m_busy[k] = lat + 1;
            end else if (sram_load) begin
                if (m_vld0[k]) m_chain[k][91:60] = m_cap0[k];
                if (m_vld1[k]) m_chain[k][37:6]  = m_cap1[k];
            end
            m_csbq[k] = global_csb;
        end
    endtask

    task automatic check_outs(input int k);
        logic [113:0] act;
        logic [113:0] exp;
        act = {scan_out[k], busy_o[k], csb0_o[k], web0_o[k], csb1_o[k], web1_o[k], sel_o[k],
               addr0_o[k], din0_o[k], wmask0_o[k], addr1_o[k], din1_o[k], wmask1_o[k]};
        exp = {m_chain[k][111], (m_busy[k] > 0), m_csb0[k], m_web0[k], m_csb1[k], m_web1[k],
               m_pkt[k][111:108], m_pkt[k][107:92], m_pkt[k][91:60], m_pkt[k][57:54],
               m_pkt[k][53:38], m_pkt[k][37:6], m_pkt[k][3:0]};
        n_asserts++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL outs_dut%0d t=%0t observed=%h expected=%h", k, $time, act, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_outs(k);
            if (csb0_o[k] === 1'b0) n_c0low[k]++;
            if (csb1_o[k] === 1'b0) n_c1low[k]++;
            if (busy_o[k] === 1'b1) n_busy[k]++;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            n_c0low[k] = 0;
            n_c1low[k] = 0;
            n_busy[k]  = 0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic shift_in(input logic [CW-1:0] p);
        for (int i = CW - 1; i >= 0; i--) begin
            scan_en = 1'b1;
            scan_in = p[i];
            step();
        end
        scan_en = 1'b0;
    endtask

    task automatic shift_out(output logic [CW-1:0] got0, output logic [CW-1:0] got1);
        for (int i = CW - 1; i >= 0; i--) begin
            got0[i] = scan_out[0];
            got1[i] = scan_out[1];
            scan_en = 1'b1;
            scan_in = 1'b0;
            step();
        end
        scan_en = 1'b0;
    endtask

    task automatic do_load();
        sram_load = 1'b1;
        step();
        step();
        sram_load = 1'b0;
    endtask

    // dout carries base+c during the c-th cycle after the issue edge, so the
    // captured value reveals exactly which cycle was sampled.
    task automatic run_access(input logic [31:0] b0, input logic [31:0] b1, input int hold,
                              input bit noisy);
        clear_counts();
        global_csb = 1'b0;
        step();
        for (int c = 0; c < 6; c++) begin
            dout0_i = b0 + 32'(c);
            dout1_i = b1 + 32'(c);
            if (c >= hold - 1) global_csb = 1'b1;
            scan_en = noisy && (c < 3);
            scan_in = 1'($urandom);
            step();
        end
        scan_en    = 1'b0;
        global_csb = 1'b1;
    endtask

    initial begin
        logic [CW-1:0] p;
        logic [CW-1:0] exp;
        logic [CW-1:0] g0;
        logic [CW-1:0] g1;
        logic [31:0]   b0;
        logic [31:0]   b1;

        resetn     = 1'b0;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        global_csb = 1'b1;
        sram_load  = 1'b0;
        dout0_i    = '0;
        dout1_i    = '0;
        clear_counts();

        // Reset state
        step();
        step();
        resetn = 1'b1;
        chk("rst_csb0", 128'(csb0_o[0]), 128'(1));
        chk("rst_web1", 128'(web1_o[0]), 128'(1));
        chk("rst_busy", 128'(busy_o[1]), 128'(0));
        chk("rst_scan_out", 128'(scan_out[0]), 128'(0));
        chk("rst_addr0", 128'(addr0_o[0]), 128'(0));

        // Single write on port 0
        p = pack(4'd0, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
        shift_in(p);
        run_access($urandom, $urandom, 1, 1'b0);
        chk("t1_csb0_low_cycles", 128'(n_c0low[0]), 128'(1));
        chk("t1_csb1_low_cycles", 128'(n_c1low[0]), 128'(0));
        chk("t1_busy_cycles_lat1", 128'(n_busy[0]), 128'(2));
        chk("t1_busy_cycles_lat3", 128'(n_busy[1]), 128'(4));
        chk("t1_addr0_hold", 128'(addr0_o[0]), 128'(1));
        chk("t1_din0_hold", 128'(din0_o[0]), 128'(1));
        chk("t1_wmask0_hold", 128'(wmask0_o[0]), 128'(4'hF));

        // Dual-port read, load, shift out
        do_reset();
        p = pack(4'd3, 16'd1, 32'h5A5A5A5A, 1'b0, 1'b1, 4'h0, 16'd2, 32'hC3C3C3C3, 1'b0, 1'b1, 4'h0);
        shift_in(p);
        run_access(32'd0, 32'd1, 1, 1'b0);
        do_load();
        shift_out(g0, g1);
        chk("t2_stream_lat1", 128'(g0),
            128'(pack(4'd3, 16'd1, 32'd1, 1'b0, 1'b1, 4'h0, 16'd2, 32'd2, 1'b0, 1'b1, 4'h0)));
        chk("t2_stream_lat3", 128'(g1),
            128'(pack(4'd3, 16'd1, 32'd3, 1'b0, 1'b1, 4'h0, 16'd2, 32'd4, 1'b0, 1'b1, 4'h0)));

        // Chain pass-through
        p = rand_pkt();
        shift_in(p);
        chk("t3_msb_at_112", 128'(scan_out[0]), 128'(p[111]));
        shift_out(g0, g1);
        chk("t3_passthru_lat1", 128'(g0), 128'(p));
        chk("t3_passthru_lat3", 128'(g1), 128'(p));

        // Held strobe issues once; write never captures
        do_reset();
        p = pack(4'd1, 16'h1234, 32'hDEADBEEF, 1'b0, 1'b0, 4'h5, 16'h0042, 32'h01020304, 1'b1, 1'b1, 4'h0);
        shift_in(p);
        run_access($urandom, $urandom, 5, 1'b0);
        chk("t4_held_single_issue", 128'(n_c0low[0]), 128'(1));
        run_access($urandom, $urandom, 1, 1'b0);
        chk("t4_second_issue", 128'(n_c0low[0]), 128'(1));
        do_load();
        shift_out(g0, g1);
        chk("t4_write_no_capture", 128'(g0), 128'(p));

        // Both ports deselected
        p = pack(4'd2, 16'h00AA, 32'h11111111, 1'b1, 1'b1, 4'h0, 16'h00BB, 32'h22222222, 1'b1, 1'b0, 4'h0);
        shift_in(p);
        run_access($urandom, $urandom, 1, 1'b0);
        chk("t4b_desel_busy", 128'(n_busy[0]), 128'(2));
        chk("t4b_desel_strobes", 128'(n_c0low[0] + n_c1low[0]), 128'(0));
        do_load();
        shift_out(g0, g1);
        chk("t4b_desel_chain", 128'(g0), 128'(p));

        // Latency 3 with shift activity during the access
        do_reset();
        p = rand_pkt();
        p[59] = 1'b0; p[58] = 1'b1; p[5] = 1'b0; p[4] = 1'b1;
        b0 = $urandom;
        b1 = $urandom;
        shift_in(p);
        run_access(b0, b1, 1, 1'b1);
        chk("t5_busy_cycles_lat3", 128'(n_busy[1]), 128'(4));
        do_load();
        shift_out(g0, g1);
        exp = p;
        exp[91:60] = b0 + 32'd3;
        exp[37:6]  = b1 + 32'd3;
        chk("t5_frozen_capture_lat3", 128'(g1), 128'(exp));

        // Reset during the wait phase
        do_reset();
        p = pack(4'd7, 16'd9, 32'd0, 1'b0, 1'b1, 4'h0, 16'd8, 32'd0, 1'b0, 1'b1, 4'h0);
        shift_in(p);
        dout0_i = $urandom;
        dout1_i = $urandom;
        global_csb = 1'b0;
        step();
        global_csb = 1'b1;
        step();
        step();
        do_reset();
        sram_load = 1'b1;
        step();
        sram_load = 1'b0;
        chk("t6_csb0", 128'(csb0_o[1]), 128'(1));
        chk("t6_csb1", 128'(csb1_o[1]), 128'(1));
        chk("t6_busy", 128'(busy_o[1]), 128'(0));
        shift_out(g0, g1);
        chk("t6_chain_zero_lat1", 128'(g0), 128'(0));
        chk("t6_chain_zero_lat3", 128'(g1), 128'(0));

        // Randomized packets, strobe widths, loads and shift noise
        for (int it = 0; it < 15; it++) begin
            p = rand_pkt();
            shift_in(p);
            run_access($urandom, $urandom, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) do_load();
            shift_out(g0, g1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
